// File: rtl/tx_symbol_pacer.sv
// Symbol pacer: buffers 4D PAM5 vectors in a small FIFO and releases one per
// symbol period to the line driver, substituting idle symbols on underrun.
module tx_symbol_pacer #(
   parameter int SYMB_PERIOD = 4,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          io_enable,
   input  logic                          io_flush,
   input  logic                          io_clear_status,
   input  logic                          io_tx_symb_vector_valid,
   output logic                          io_tx_symb_vector_ready,
   input  logic [2:0]                    io_tx_symb_vector_bits_0,
   input  logic [2:0]                    io_tx_symb_vector_bits_1,
   input  logic [2:0]                    io_tx_symb_vector_bits_2,
   input  logic [2:0]                    io_tx_symb_vector_bits_3,
   output logic                          io_symb_timer_done,
   output logic [2:0]                    io_line_a,
   output logic [2:0]                    io_line_b,
   output logic [2:0]                    io_line_c,
   output logic [2:0]                    io_line_d,
   output logic                          io_line_valid,
   output logic                          io_underrun,
   output logic                          io_code_error,
   output logic [$clog2(FIFO_DEPTH):0]   io_level
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = (SYMB_PERIOD > 1) ? $clog2(SYMB_PERIOD) : 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(SYMB_PERIOD - 1);
   localparam logic [TW-1:0] TIMER_ZERO = TW'(0);
   localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
   localparam logic [AW-1:0] PTR_ZERO   = AW'(0);
   localparam logic [AW-1:0] PTR_ONE    = AW'(1);
   localparam logic [AW:0]   CNT_ZERO   = (AW + 1)'(0);
   localparam logic [AW:0]   CNT_ONE    = (AW + 1)'(1);
   localparam logic [AW:0]   CNT_FULL   = (AW + 1)'(FIFO_DEPTH);

   // PAM5 codes 011, 100 and 101 have no symbol meaning; they go out as idle.
   function automatic logic pam5_illegal(input logic [2:0] code);
      case (code)
         3'b011, 3'b100, 3'b101: pam5_illegal = 1'b1;
         default:                pam5_illegal = 1'b0;
      endcase
   endfunction

   function automatic logic [2:0] pam5_sanitize(input logic [2:0] code);
      if (pam5_illegal(code)) begin
         pam5_sanitize = 3'b000;
      end else begin
         pam5_sanitize = code;
      end
   endfunction

   logic [11:0]   mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [11:0]   line_q, line_d;
   logic          line_valid_q, line_valid_d;
   logic          done_q, done_d;
   logic          underrun_q, underrun_d;
   logic          code_error_q, code_error_d;

   logic          tick_s, push_s, pop_s, head_bad_s;
   logic [11:0]   head_s, head_clean_s, push_vec_s;

   assign push_vec_s   = {io_tx_symb_vector_bits_0, io_tx_symb_vector_bits_1,
                          io_tx_symb_vector_bits_2, io_tx_symb_vector_bits_3};
   assign head_s       = mem_q[rd_ptr_q];
   assign head_clean_s = {pam5_sanitize(head_s[11:9]), pam5_sanitize(head_s[8:6]),
                          pam5_sanitize(head_s[5:3]),  pam5_sanitize(head_s[2:0])};
   assign head_bad_s   = pam5_illegal(head_s[11:9]) | pam5_illegal(head_s[8:6]) |
                         pam5_illegal(head_s[5:3])  | pam5_illegal(head_s[2:0]);

   // Next-state logic for timer, FIFO bookkeeping, line outputs and sticky flags.
   always_comb begin
      tick_s  = io_enable && (timer_q == TIMER_LAST);
      push_s  = io_tx_symb_vector_valid && io_tx_symb_vector_ready && !io_flush;
      pop_s   = tick_s && (count_q != CNT_ZERO) && !io_flush;
      done_d  = tick_s;

      if (!io_enable) begin
         timer_d = TIMER_ZERO;
      end else if (tick_s) begin
         timer_d = TIMER_ZERO;
      end else begin
         timer_d = timer_q + TIMER_ONE;
      end

      if (io_flush) begin
         wr_ptr_d = PTR_ZERO;
         rd_ptr_d = PTR_ZERO;
         count_d  = CNT_ZERO;
      end else begin
         wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
         rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
         case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end

      // Disabling the pacer idles the line immediately; otherwise it only moves on a tick.
      if (!io_enable) begin
         line_d       = 12'h000;
         line_valid_d = 1'b0;
      end else if (tick_s) begin
         line_d       = pop_s ? head_clean_s : 12'h000;
         line_valid_d = pop_s;
      end else begin
         line_d       = line_q;
         line_valid_d = line_valid_q;
      end

      if (tick_s && !pop_s) begin
         underrun_d = 1'b1;
      end else if (io_clear_status) begin
         underrun_d = 1'b0;
      end else begin
         underrun_d = underrun_q;
      end

      if (pop_s && head_bad_s) begin
         code_error_d = 1'b1;
      end else if (io_clear_status) begin
         code_error_d = 1'b0;
      end else begin
         code_error_d = code_error_q;
      end
   end

   // Control and output registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q     <= PTR_ZERO;
         rd_ptr_q     <= PTR_ZERO;
         count_q      <= CNT_ZERO;
         timer_q      <= TIMER_ZERO;
         line_q       <= 12'h000;
         line_valid_q <= 1'b0;
         done_q       <= 1'b0;
         underrun_q   <= 1'b0;
         code_error_q <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         timer_q      <= timer_d;
         line_q       <= line_d;
         line_valid_q <= line_valid_d;
         done_q       <= done_d;
         underrun_q   <= underrun_d;
         code_error_q <= code_error_d;
      end
   end

   // FIFO storage.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= 12'h000;
         end
      end else if (push_s) begin
         mem_q[wr_ptr_q] <= push_vec_s;
      end else begin
         mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
      end
   end

   assign io_tx_symb_vector_ready = (count_q != CNT_FULL);
   assign io_symb_timer_done      = done_q;
   assign io_line_a               = line_q[11:9];
   assign io_line_b               = line_q[8:6];
   assign io_line_c               = line_q[5:3];
   assign io_line_d               = line_q[2:0];
   assign io_line_valid           = line_valid_q;
   assign io_underrun             = underrun_q;
   assign io_code_error           = code_error_q;
   assign io_level                = count_q;

endmodule

// File: tb/tb_tx_symbol_pacer.sv
// Bench for tx_symbol_pacer: scoreboard of accepted vectors checked at every
// strobe, plus scenario tasks with their own targeted comparisons.
module tb_tx_symbol_pacer;

   localparam int P = 4;
   localparam int D = 4;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       io_enable = 1'b0, io_flush = 1'b0, io_clear_status = 1'b0;
   logic       io_tx_symb_vector_valid = 1'b0;
   logic       io_tx_symb_vector_ready;
   logic [2:0] bits_0 = 3'd0, bits_1 = 3'd0, bits_2 = 3'd0, bits_3 = 3'd0;
   logic       io_symb_timer_done, io_line_valid, io_underrun, io_code_error;
   logic [2:0] io_line_a, io_line_b, io_line_c, io_line_d;
   logic [2:0] io_level;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [11:0] sb[$];
   int          m_timer = 0;
   logic        m_under = 1'b0, m_cerr = 1'b0, exp_lv = 1'b0, last_tick = 1'b0;
   logic [11:0] exp_line = 12'h000;
   int          n_pops = 0;

   tx_symbol_pacer #(.SYMB_PERIOD(P), .FIFO_DEPTH(D)) dut (
      .clock(clock), .reset(reset), .io_enable(io_enable), .io_flush(io_flush),
      .io_clear_status(io_clear_status),
      .io_tx_symb_vector_valid(io_tx_symb_vector_valid),
      .io_tx_symb_vector_ready(io_tx_symb_vector_ready),
      .io_tx_symb_vector_bits_0(bits_0), .io_tx_symb_vector_bits_1(bits_1),
      .io_tx_symb_vector_bits_2(bits_2), .io_tx_symb_vector_bits_3(bits_3),
      .io_symb_timer_done(io_symb_timer_done),
      .io_line_a(io_line_a), .io_line_b(io_line_b), .io_line_c(io_line_c), .io_line_d(io_line_d),
      .io_line_valid(io_line_valid), .io_underrun(io_underrun),
      .io_code_error(io_code_error), .io_level(io_level)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [2:0] legal_lane(input logic [2:0] c);
      return (c == 3'b011 || c == 3'b100 || c == 3'b101) ? 3'b000 : c;
   endfunction

   function automatic logic [11:0] legal_vec(input logic [11:0] v);
      return {legal_lane(v[11:9]), legal_lane(v[8:6]), legal_lane(v[5:3]), legal_lane(v[2:0])};
   endfunction

   function automatic logic has_bad(input logic [11:0] v);
      return (legal_vec(v) != v);
   endfunction

   task automatic drive_vec(input logic [11:0] v);
      {bits_0, bits_1, bits_2, bits_3} = v;
   endtask

   task automatic model_reset();
      sb.delete();
      m_timer = 0; m_under = 1'b0; m_cerr = 1'b0; exp_lv = 1'b0; exp_line = 12'h000;
      last_tick = 1'b0;
   endtask

   // One clock: snapshot inputs, advance the reference, then check the DUT at the negedge.
   task automatic cycle();
      logic acc, en, fl, clr, tk;
      logic [11:0] v, head;
      acc = io_tx_symb_vector_valid && io_tx_symb_vector_ready && !io_flush;
      v   = {bits_0, bits_1, bits_2, bits_3};
      en  = io_enable; fl = io_flush; clr = io_clear_status;
      tk  = en && (m_timer == P - 1);
      m_timer = (!en || tk) ? 0 : m_timer + 1;
      @(posedge clock);
      @(negedge clock);
      if (clr) begin m_under = 1'b0; m_cerr = 1'b0; end
      if (fl) sb.delete();
      if (!en) begin
         exp_line = 12'h000; exp_lv = 1'b0;
      end else if (tk) begin
         if (sb.size() > 0) begin
            head = sb.pop_front();
            exp_line = legal_vec(head); exp_lv = 1'b1; n_pops++;
            if (has_bad(head)) m_cerr = 1'b1;
         end else begin
            exp_line = 12'h000; exp_lv = 1'b0; m_under = 1'b1;
         end
      end
      if (acc) sb.push_back(v);
      last_tick = tk;
      n_checks += 6;
      if (io_symb_timer_done !== tk) begin n_fail++; $display("FAIL strobe: got %b expected %b at %0t", io_symb_timer_done, tk, $time); end
      if ({io_line_a, io_line_b, io_line_c, io_line_d} !== exp_line) begin n_fail++; $display("FAIL line: got %o expected %o at %0t", {io_line_a, io_line_b, io_line_c, io_line_d}, exp_line, $time); end
      if (io_line_valid !== exp_lv) begin n_fail++; $display("FAIL line_valid: got %b expected %b at %0t", io_line_valid, exp_lv, $time); end
      if (io_underrun !== m_under) begin n_fail++; $display("FAIL underrun: got %b expected %b at %0t", io_underrun, m_under, $time); end
      if (io_code_error !== m_cerr) begin n_fail++; $display("FAIL code_error: got %b expected %b at %0t", io_code_error, m_cerr, $time); end
      if (io_level !== 3'(sb.size())) begin n_fail++; $display("FAIL level: got %0d expected %0d at %0t", io_level, sb.size(), $time); end
   endtask

   task automatic clear_status();
      io_clear_status = 1'b1; cycle(); io_clear_status = 1'b0;
   endtask

   task automatic push_one(input logic [11:0] v);
      drive_vec(v); io_tx_symb_vector_valid = 1'b1; cycle(); io_tx_symb_vector_valid = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clock);
      n_checks += 4;
      if (io_tx_symb_vector_ready !== 1'b1 || io_level !== 3'd0) begin n_fail++; $display("FAIL reset_fifo: got ready=%b level=%0d expected ready=1 level=0", io_tx_symb_vector_ready, io_level); end
      if ({io_line_a, io_line_b, io_line_c, io_line_d} !== 12'h000 || io_line_valid !== 1'b0) begin n_fail++; $display("FAIL reset_line: got %o/%b expected 0/0", {io_line_a, io_line_b, io_line_c, io_line_d}, io_line_valid); end
      if (io_symb_timer_done !== 1'b0) begin n_fail++; $display("FAIL reset_strobe: got %b expected 0", io_symb_timer_done); end
      if (io_underrun !== 1'b0 || io_code_error !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got %b%b expected 00", io_underrun, io_code_error); end
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_basic();
      int strobes = 0;
      logic [11:0] first_line = 12'h000;
      logic first_lv = 1'b0;
      io_enable = 1'b1;
      push_one({3'b001, 3'b010, 3'b111, 3'b110});
      repeat (12) begin
         cycle();
         if (last_tick) begin
            strobes++;
            if (strobes == 1) begin first_line = {io_line_a, io_line_b, io_line_c, io_line_d}; first_lv = io_line_valid; end
         end
      end
      n_checks += 3;
      if (strobes != 3) begin n_fail++; $display("FAIL basic_strobes: got %0d expected 3", strobes); end
      if (first_line !== 12'o1276 || first_lv !== 1'b1) begin n_fail++; $display("FAIL basic_first: got %o/%b expected 1276/1", first_line, first_lv); end
      if (io_underrun !== 1'b1 || io_line_valid !== 1'b0) begin n_fail++; $display("FAIL basic_underrun: got %b/%b expected 1/0", io_underrun, io_line_valid); end
   endtask

   task automatic test_back_to_back();
      logic [11:0] vecs[8] = '{12'o1267, 12'o2671, 12'o6712, 12'o7126, 12'o0126, 12'o1260, 12'o2601, 12'o6012};
      int k = 0, peak = 0, pops0;
      logic saw_block = 1'b0, rdy;
      clear_status();
      pops0 = n_pops;
      io_tx_symb_vector_valid = 1'b1;
      for (int c = 0; c < 60 && k < 8; c++) begin
         drive_vec(vecs[k]);
         rdy = io_tx_symb_vector_ready;
         if (!rdy) saw_block = 1'b1;
         cycle();
         if (rdy) k++;
         if (int'(io_level) > peak) peak = int'(io_level);
      end
      io_tx_symb_vector_valid = 1'b0;
      repeat (40) cycle();
      n_checks += 4;
      if (k != 8) begin n_fail++; $display("FAIL b2b_pushes: got %0d expected 8", k); end
      if (peak != 4) begin n_fail++; $display("FAIL b2b_peak: got %0d expected 4", peak); end
      if (saw_block !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_drop: got %b expected 1", saw_block); end
      if (n_pops - pops0 != 8) begin n_fail++; $display("FAIL b2b_pops: got %0d expected 8", n_pops - pops0); end
   endtask

   task automatic test_code_error();
      logic found = 1'b0;
      clear_status();
      push_one({3'b001, 3'b011, 3'b010, 3'b100});
      for (int c = 0; c < 12; c++) begin
         cycle();
         if (last_tick && io_line_valid) begin found = 1'b1; break; end
      end
      n_checks += 4;
      if (found !== 1'b1 || {io_line_a, io_line_b, io_line_c, io_line_d} !== 12'o1020) begin n_fail++; $display("FAIL code_line: got %o found=%b expected 1020", {io_line_a, io_line_b, io_line_c, io_line_d}, found); end
      if (io_code_error !== 1'b1) begin n_fail++; $display("FAIL code_set: got %b expected 1", io_code_error); end
      repeat (3) cycle();
      if (io_code_error !== 1'b1) begin n_fail++; $display("FAIL code_sticky: got %b expected 1", io_code_error); end
      clear_status();
      if (io_code_error !== 1'b0) begin n_fail++; $display("FAIL code_clear: got %b expected 0", io_code_error); end
   endtask

   task automatic test_full_tick();
      logic [11:0] fill[4] = '{12'o0012, 12'o0120, 12'o1200, 12'o2001};
      logic ticked = 1'b0;
      io_enable = 1'b0;
      cycle();
      for (int k = 0; k < 4; k++) push_one(fill[k]);
      n_checks += 1;
      if (io_level !== 3'd4 || io_tx_symb_vector_ready !== 1'b0) begin n_fail++; $display("FAIL full_fill: got level=%0d ready=%b expected 4/0", io_level, io_tx_symb_vector_ready); end
      io_enable = 1'b1;
      drive_vec(12'o7777);
      io_tx_symb_vector_valid = 1'b1;
      for (int c = 0; c < 8; c++) begin
         cycle();
         if (last_tick) begin ticked = 1'b1; break; end
         n_checks++;
         if (io_level !== 3'd4) begin n_fail++; $display("FAIL full_hold: got %0d expected 4", io_level); end
      end
      n_checks += 2;
      if (ticked !== 1'b1 || io_level !== 3'd3) begin n_fail++; $display("FAIL full_pop: got level=%0d ticked=%b expected 3/1", io_level, ticked); end
      if (io_tx_symb_vector_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready: got %b expected 1", io_tx_symb_vector_ready); end
      cycle();
      io_tx_symb_vector_valid = 1'b0;
      n_checks++;
      if (io_level !== 3'd4) begin n_fail++; $display("FAIL full_refill: got %0d expected 4", io_level); end
   endtask

   task automatic test_flush();
      logic ticked = 1'b0;
      io_enable = 1'b0;
      io_flush = 1'b1; cycle(); io_flush = 1'b0;
      push_one(12'o1111); push_one(12'o2222); push_one(12'o6666);
      n_checks += 2;
      if (io_level !== 3'd3) begin n_fail++; $display("FAIL flush_pre: got %0d expected 3", io_level); end
      drive_vec(12'o7777);
      io_flush = 1'b1; io_tx_symb_vector_valid = 1'b1;
      cycle();
      io_flush = 1'b0; io_tx_symb_vector_valid = 1'b0;
      if (io_level !== 3'd0) begin n_fail++; $display("FAIL flush_level: got %0d expected 0", io_level); end
      clear_status();
      io_enable = 1'b1;
      for (int c = 0; c < 8; c++) begin
         cycle();
         if (last_tick) begin ticked = 1'b1; break; end
      end
      n_checks++;
      if (ticked !== 1'b1 || io_underrun !== 1'b1 || io_line_valid !== 1'b0) begin n_fail++; $display("FAIL flush_underrun: got ticked=%b underrun=%b valid=%b expected 1/1/0", ticked, io_underrun, io_line_valid); end
   endtask

   task automatic test_enable_drop();
      int strobes = 0, lat = 0;
      io_enable = 1'b0;
      io_flush = 1'b1; cycle(); io_flush = 1'b0;
      clear_status();
      push_one(12'o1111); push_one(12'o2222);
      io_enable = 1'b1;
      cycle(); cycle();
      io_enable = 1'b0;
      repeat (6) begin cycle(); if (io_symb_timer_done) strobes++; end
      n_checks += 3;
      if (strobes != 0) begin n_fail++; $display("FAIL drop_strobes: got %0d expected 0", strobes); end
      if ({io_line_a, io_line_b, io_line_c, io_line_d} !== 12'h000 || io_level !== 3'd2) begin n_fail++; $display("FAIL drop_hold: got line=%o level=%0d expected 0/2", {io_line_a, io_line_b, io_line_c, io_line_d}, io_level); end
      io_enable = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         cycle();
         if (last_tick) begin lat = c; break; end
      end
      if (lat != P || {io_line_a, io_line_b, io_line_c, io_line_d} !== 12'o1111) begin n_fail++; $display("FAIL drop_resume: got latency=%0d line=%o expected %0d/1111", lat, {io_line_a, io_line_b, io_line_c, io_line_d}, P); end
   endtask

   task automatic test_reset_mid();
      push_one(12'o2727); push_one(12'o7272);
      @(posedge clock);
      #2 reset = 1'b1;
      #1;
      n_checks += 3;
      if (io_level !== 3'd0 || io_tx_symb_vector_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_fifo: got level=%0d ready=%b expected 0/1", io_level, io_tx_symb_vector_ready); end
      if ({io_line_a, io_line_b, io_line_c, io_line_d} !== 12'h000 || io_line_valid !== 1'b0 || io_symb_timer_done !== 1'b0) begin n_fail++; $display("FAIL mid_reset_line: got %o/%b/%b expected 0/0/0", {io_line_a, io_line_b, io_line_c, io_line_d}, io_line_valid, io_symb_timer_done); end
      if (io_underrun !== 1'b0 || io_code_error !== 1'b0) begin n_fail++; $display("FAIL mid_reset_flags: got %b%b expected 00", io_underrun, io_code_error); end
      @(negedge clock);
      reset = 1'b0;
      model_reset();
      repeat (6) cycle();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_code_error();
      test_full_tick();
      test_flush();
      test_enable_drop();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tx_symbol_pacer.md
Name: tx_symbol_pacer

Overview:
- Downstream stage of the PCS encoder TX/RX state machine.
- Accepts 4D PAM5 symbol vectors (A–D, 3-bit two's complement) over a valid/ready handshake and buffers them in a small FIFO.
- Releases one vector per symbol period to the line-driver interface and generates the `io_symb_timer_done` strobe that paces the encoder.
- Substitutes zero (idle) symbols on underrun and flags illegal PAM5 codes.

Parameters:
- SYMB_PERIOD, 4, clock cycles per symbol period; legal range ≥1.
- FIFO_DEPTH, 4, entries of 12 bits each; power of two, ≥2.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- io_enable  in  1  pacing enable
- io_flush  in  1  synchronous FIFO clear
- io_clear_status  in  1  synchronous clear of the sticky flags
- io_tx_symb_vector_valid  in  1  upstream vector valid
- io_tx_symb_vector_ready  out  1  equals !full
- io_tx_symb_vector_bits_0..3  in  3 each  PAM5 symbols A, B, C, D
- io_symb_timer_done  out  1  one-cycle registered strobe at each symbol update
- io_line_a, io_line_b, io_line_c, io_line_d  out  3 each  registered line symbols
- io_line_valid  out  1  high when the current line symbols came from the FIFO
- io_underrun  out  1  sticky: a tick occurred with the FIFO empty
- io_code_error  out  1  sticky: an illegal code was popped
- io_level  out  log2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:

Reset (asynchronous):
- FIFO empty, pointers 0, timer 0.
- All io_line_* = 0, io_line_valid = 0, io_symb_timer_done = 0, sticky flags = 0.
- io_tx_symb_vector_ready = 1.

Push:
- Occurs when valid && ready at a rising edge; the vector is written at the write pointer.
- ready is derived from the registered count, so it is 0 whenever count == FIFO_DEPTH.
- Data presented while ready = 0 is ignored, not lost silently: upstream must hold it.

Timer:
- Counts 0..SYMB_PERIOD-1 while io_enable = 1, then wraps.
- tick = io_enable && (timer == SYMB_PERIOD-1).
- When io_enable = 0, the timer is held at 0 and no tick occurs.
- With SYMB_PERIOD = 1, tick fires every enabled cycle.

On tick, registered:
- io_symb_timer_done = 1 for exactly that one following cycle.
- If count > 0: pop the head into io_line_*, set io_line_valid = 1.
- If count == 0: load zeros into io_line_*, set io_line_valid = 0, set io_underrun = 1.
- Line outputs hold their value between ticks.

Code check on pop, per lane:
- Legal codes are 000, 001, 010, 110, 111 (0, +1, +2, −2, −1).
- Codes 011, 100, 101 are replaced by 000 and set io_code_error.

Simultaneous push and pop in one cycle:
- Both take effect; count is unchanged.
- Pop reads the pre-existing head, never the vector being pushed.
- If the FIFO is full, ready = 0 blocks the push.

Wrap-around:
- Pointers wrap modulo FIFO_DEPTH.
- count saturates correctly at 0 and FIFO_DEPTH, with no over- or underflow.

Latency:
- A vector pushed into an empty FIFO appears on io_line_* on the first tick whose edge is ≥1 cycle after the push edge.

io_flush (priority over push and pop):
- Pointers and count go to 0 next cycle; a push in the same cycle is discarded.
- Line outputs and timer are unaffected.

io_enable falls mid-period:
- Timer resets to 0.
- io_line_* are forced to 0 and io_line_valid to 0 next cycle.
- FIFO contents are retained; pushes are still accepted.

io_clear_status:
- Clears both sticky flags.
- If the same cycle also sets a flag, set wins.

Reset asserted mid-operation:
- Immediate return to reset values; buffered vectors are discarded.

Test Plan:
- Reset, then enable with SYMB_PERIOD = 4 and push A..D = (1, 2, −1, −2) once → io_symb_timer_done strobes every 4 cycles. The first tick after the push shows io_line = (001, 010, 111, 110) with io_line_valid = 1; the next tick shows zeros, io_line_valid = 0, io_underrun = 1.
- Hold valid = 1 continuously with 8 distinct vectors, FIFO_DEPTH = 4 → ready drops after 4 pushes. io_level peaks at 4. All 8 vectors emerge in order, one per tick, with no loss.
- Push a vector with lane B = 011 and lane D = 100 → popped line has B = 0 and D = 0, other lanes unchanged, and io_code_error = 1 until io_clear_status.
- FIFO full (level 4) with push attempted on the same cycle as a tick pop → level becomes 3 and the new vector is not accepted. On the next cycle, with ready = 1, the push is accepted and level returns to 4.
- Level 3, then assert io_flush together with a push → level is 0 next cycle. The following tick outputs zeros and flags io_underrun.
- Deassert io_enable at timer = 2 with 2 entries buffered → no strobes occur, line = 0, level stays 2. On re-enable, the first strobe arrives SYMB_PERIOD cycles later with the oldest entry. Separately, asynchronous reset mid-stream clears everything within the same cycle.
